// File: rtl/systolic_array_ctrl_if.sv
// Bundle of command, buffer-read and array-edge signals for systolic_array_ctrl.
// slave  : the sequencer's view (takes commands, drives buffer reads and array inputs).
// master : the surrounding system's view (decoder, buffers, array instance).
// Ports: start_i/vec_num_i/abort_i in, busy_o/done_o/err_o out,
//        w_rd_* / a_rd_* buffer read ports, sa_* array edge ports.
interface systolic_array_ctrl_if #(
  parameter int ROWS  = 10,
  parameter int COLS  = 5,
  parameter int CNT_W = 8
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   start_i;
  logic [CNT_W-1:0]       vec_num_i;
  logic                   abort_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   err_o;
  logic                   w_rd_en_o;
  logic [AW-1:0]          w_rd_addr_o;
  logic [COLS*9-1:0]      w_rd_data_i;
  logic                   a_rd_en_o;
  logic [CNT_W-1:0]       a_rd_addr_o;
  logic [ROWS*9-1:0]      a_rd_data_i;
  logic [COLS-1:0]        sa_en_up_o;
  logic [COLS*9-1:0]      sa_data_up_o;
  logic [ROWS-1:0]        sa_en_left_o;
  logic [ROWS*9-1:0]      sa_data_left_o;
  logic [ROWS*COLS-1:0]   sa_mode_o;
  logic [COLS-1:0]        sa_en_down_i;

  modport slave (
    input  start_i, vec_num_i, abort_i, w_rd_data_i, a_rd_data_i, sa_en_down_i,
    output busy_o, done_o, err_o, w_rd_en_o, w_rd_addr_o, a_rd_en_o, a_rd_addr_o,
           sa_en_up_o, sa_data_up_o, sa_en_left_o, sa_data_left_o, sa_mode_o
  );

  modport master (
    output start_i, vec_num_i, abort_i, w_rd_data_i, a_rd_data_i, sa_en_down_i,
    input  busy_o, done_o, err_o, w_rd_en_o, w_rd_addr_o, a_rd_en_o, a_rd_addr_o,
           sa_en_up_o, sa_data_up_o, sa_en_left_o, sa_data_left_o, sa_mode_o
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a ROWS x COLS systolic array: loads one weight tile
// (rows ROWS-1..0), streams K activation vectors into the left edge with
// per-row skew, counts bottom-edge results and reports done / timeout.
// Ports: clk, rst_n (async, active low), bus (systolic_array_ctrl_if.slave).

// One skewed activation lane: DEPTH register stages for enable and data.
module systolic_array_skew_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_en,
  input  logic [W-1:0] in_data,
  output logic         out_en,
  output logic [W-1:0] out_data
);
  logic [DEPTH:1]         vld_pipe;
  logic [DEPTH:1][W-1:0]  dat_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_en;
      dat_pipe[1] <= in_en ? in_data : '0;
      for (int s = 2; s <= DEPTH; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_en   = vld_pipe[DEPTH];
  assign out_data = dat_pipe[DEPTH];
endmodule

module systolic_array_ctrl #(
  parameter int ROWS  = 10,
  parameter int COLS  = 5,
  parameter int CNT_W = 8,
  parameter int TMO   = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_array_ctrl_if.slave  bus
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW = $clog2(ROWS + 1);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   k_q, a_cnt, res_cnt;
  logic [LW-1:0]      ld_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic               w_vld, a_vld, done_q, err_q;
  logic               done_nx, err_nx;
  logic               abort, w_rd_en, a_rd_en, res_pulse, res_hit;
  logic [CNT_W:0]     res_sum;

  logic [ROWS-1:0][8:0] a_row, left_dat;
  logic [ROWS-1:0]      left_en;

  assign abort     = bus.abort_i && (state != IDLE);
  assign w_rd_en   = (state == LOAD) && (ld_cnt < LW'(ROWS));
  assign a_rd_en   = (state == COMPUTE);
  // Results only count once compute has begun; stray pulses earlier are noise.
  assign res_pulse = bus.sa_en_down_i[COLS-1] && (state == COMPUTE || state == DRAIN);
  // Include this cycle's pulse so done lands the cycle after the Kth result.
  assign res_sum   = {1'b0, res_cnt} + {{CNT_W{1'b0}}, res_pulse};
  assign res_hit   = (res_sum >= {1'b0, k_q});

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: if (bus.start_i) begin
        if (bus.vec_num_i == '0) done_nx  = 1'b1;
        else                     state_nx = LOAD;
      end
      // One extra LOAD cycle lets the last weight row land on the top edge.
      LOAD:    if (ld_cnt == LW'(ROWS)) state_nx = COMPUTE;
      COMPUTE: if (a_cnt == k_q - CNT_W'(1)) state_nx = DRAIN;
      DRAIN: begin
        if (res_hit) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (tmo_cnt == TW'(TMO - 1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle completion.
    if (abort) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k_q     <= '0;
      ld_cnt  <= '0;
      a_cnt   <= '0;
      tmo_cnt <= '0;
      res_cnt <= '0;
      w_vld   <= 1'b0;
      a_vld   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
      if (state == IDLE && bus.start_i) k_q <= bus.vec_num_i;
      ld_cnt  <= (state == LOAD    && !abort) ? ld_cnt  + LW'(1)    : '0;
      a_cnt   <= (state == COMPUTE && !abort) ? a_cnt   + CNT_W'(1) : '0;
      tmo_cnt <= (state == DRAIN   && !abort) ? tmo_cnt + TW'(1)    : '0;
      if (abort || state == IDLE || state == LOAD) res_cnt <= '0;
      else                                         res_cnt <= res_sum[CNT_W-1:0];
      w_vld   <= w_rd_en && !abort;
      a_vld   <= a_rd_en && !abort;
    end
  end

  // Skew: row i sees i register stages; row 0 drives straight from the buffer.
  assign a_row = bus.a_rd_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_lane
      if (gi == 0) begin : g_direct
        assign left_en[gi]  = a_vld;
        assign left_dat[gi] = a_vld ? a_row[gi] : 9'd0;
      end else begin : g_skew
        systolic_array_skew_lane #(.DEPTH(gi), .W(9)) u_lane (
          .clk      (clk),
          .rst_n    (rst_n),
          .clr      (abort),
          .in_en    (a_vld),
          .in_data  (a_row[gi]),
          .out_en   (left_en[gi]),
          .out_data (left_dat[gi])
        );
      end
    end
    if (COLS > 1) begin : g_unused
      logic unused_down;
      assign unused_down = ^bus.sa_en_down_i[COLS-2:0];
    end
  endgenerate

  assign bus.busy_o         = (state != IDLE);
  assign bus.done_o         = done_q;
  assign bus.err_o          = err_q;
  assign bus.w_rd_en_o      = w_rd_en;
  assign bus.w_rd_addr_o    = w_rd_en ? AW'(ROWS - 1 - int'(ld_cnt)) : '0;
  assign bus.a_rd_en_o      = a_rd_en;
  assign bus.a_rd_addr_o    = a_rd_en ? a_cnt : '0;
  assign bus.sa_en_up_o     = {COLS{w_vld}};
  assign bus.sa_data_up_o   = w_vld ? bus.w_rd_data_i : '0;
  assign bus.sa_en_left_o   = left_en;
  assign bus.sa_data_left_o = left_dat;
  assign bus.sa_mode_o      = {(ROWS*COLS){state == LOAD}};
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl (ROWS=10, COLS=5, K up to 8).
// Outputs are sampled 1 time unit after each rising edge; inputs change then too.
module tb_systolic_array_ctrl;
  localparam int ROWS = 10;
  localparam int COLS = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [8:0] a_mem [0:15][0:ROWS-1];

  systolic_array_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(8)) bus ();

  systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(8), .TMO(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Buffer models: one-cycle read latency. Weight row r has every column = r*3.
  always @(posedge clk) begin
    if (bus.w_rd_en_o) bus.w_rd_data_i <= {COLS{9'(bus.w_rd_addr_o) * 9'd3}};
    if (bus.a_rd_en_o)
      for (int i = 0; i < ROWS; i++) bus.a_rd_data_i[9*i +: 9] <= a_mem[bus.a_rd_addr_o[3:0]][i];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a job in the current cycle T and return at C = T+ROWS+2.
  task automatic go_to_compute(input logic [7:0] k);
    bus.vec_num_i = k;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
    repeat (ROWS + 1) tick();
  endtask

  initial begin
    logic [89:0] exp_dat;
    logic [9:0]  exp_en;
    logic [8:0]  wv;
    int          n_done;

    for (int v = 0; v < 16; v++)
      for (int i = 0; i < ROWS; i++) a_mem[v][i] = 9'(v*16 + i + 1);

    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.vec_num_i    = '0;
    bus.abort_i      = 1'b0;
    bus.sa_en_down_i = '0;
    repeat (3) tick();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_wen",  bus.w_rd_en_o, 0);
    chk("rst_mode", bus.sa_mode_o, 0);
    chk("rst_left", bus.sa_en_left_o, 0);
    rst_n = 1'b1;
    tick();

    // ---- K=3: load sequence, mode window, row-9 skew, done once ----
    bus.vec_num_i = 8'd3;
    bus.start_i   = 1'b1;
    tick();                                   // T+1
    bus.start_i   = 1'b0;
    for (int k = 1; k <= ROWS; k++) begin     // cycles T+1..T+10
      chk("ld_busy", bus.busy_o, 1);
      chk("ld_wen",  bus.w_rd_en_o, 1);
      chk("ld_addr", bus.w_rd_addr_o, 10 - k);
      chk("ld_mode", bus.sa_mode_o, {50{1'b1}});
      if (k >= 2) begin
        wv = 9'((11 - k) * 3);
        chk("ld_enup",  bus.sa_en_up_o, 5'h1f);
        chk("ld_dataup", bus.sa_data_up_o, {5{wv}});
      end else begin
        chk("ld_enup0", bus.sa_en_up_o, 0);
      end
      // A result pulse during LOAD must not be counted.
      bus.sa_en_down_i = (k == 5) ? 5'b10000 : 5'b00000;
      tick();
    end
    chk("ld_last_wen",  bus.w_rd_en_o, 0);    // T+11
    chk("ld_last_mode", bus.sa_mode_o, {50{1'b1}});
    chk("ld_last_enup", bus.sa_en_up_o, 5'h1f);
    chk("ld_last_data", bus.sa_data_up_o, 0);
    tick();                                   // C
    n_done = 0;
    for (int j = 0; j <= 13; j++) begin
      chk("k3_mode", bus.sa_mode_o, 0);
      chk("k3_enup", bus.sa_en_up_o, 0);
      chk("k3_aen",  bus.a_rd_en_o, (j < 3) ? 1 : 0);
      if (j < 3) chk("k3_aaddr", bus.a_rd_addr_o, j);
      chk("k3_row0_en", bus.sa_en_left_o[0], (j >= 1 && j <= 3) ? 1 : 0);
      chk("k3_row9_en", bus.sa_en_left_o[9], (j >= 10 && j <= 12) ? 1 : 0);
      if (j >= 10 && j <= 12) chk("k3_row9_dat", bus.sa_data_left_o[89:81], (j - 10)*16 + 10);
      chk("k3_done", bus.done_o, (j == 8) ? 1 : 0);
      chk("k3_err",  bus.err_o, 0);
      chk("k3_busy", bus.busy_o, (j < 8) ? 1 : 0);
      if (bus.done_o) n_done++;
      bus.sa_en_down_i = (j >= 5 && j <= 7) ? 5'b10000 : 5'b00000;
      tick();
    end
    chk("k3_done_once", n_done, 1);

    // ---- K=1 skew check: row i carries i+1 exactly at C+1+i ----
    go_to_compute(8'd1);
    for (int j = 0; j <= 11; j++) begin
      exp_dat = '0;
      exp_en  = '0;
      for (int i = 0; i < ROWS; i++)
        if (j == i + 1) begin
          exp_dat[9*i +: 9] = 9'(i + 1);
          exp_en[i]         = 1'b1;
        end
      chk("skew_data", bus.sa_data_left_o, exp_dat);
      chk("skew_en",   bus.sa_en_left_o, exp_en);
      chk("skew_done", bus.done_o, (j == 4) ? 1 : 0);
      bus.sa_en_down_i = (j == 3) ? 5'b10000 : 5'b00000;
      tick();
    end

    // ---- Timeout: K=4, only 2 results; DRAIN starts at C+4 ----
    go_to_compute(8'd4);
    for (int j = 0; j <= 30; j++) begin
      chk("tmo_done", bus.done_o, (j == 28) ? 1 : 0);
      chk("tmo_err",  bus.err_o,  (j == 28) ? 1 : 0);
      chk("tmo_busy", bus.busy_o, (j < 28) ? 1 : 0);
      bus.sa_en_down_i = (j == 1 || j == 5) ? 5'b10000 : 5'b00000;
      tick();
    end

    // ---- Abort at C+2 with K=8 ----
    go_to_compute(8'd8);
    tick();
    tick();                                   // C+2
    bus.abort_i = 1'b1;
    tick();                                   // C+3
    bus.abort_i = 1'b0;
    chk("ab_busy",  bus.busy_o, 0);
    chk("ab_aen",   bus.a_rd_en_o, 0);
    chk("ab_mode",  bus.sa_mode_o, 0);
    chk("ab_enup",  bus.sa_en_up_o, 0);
    chk("ab_dleft", bus.sa_data_left_o, 0);
    for (int j = 0; j < 12; j++) begin
      chk("ab_left_quiet", bus.sa_en_left_o, 0);
      chk("ab_no_done",    bus.done_o, 0);
      tick();
    end
    // Fresh K=1 job; a start during DRAIN must be ignored.
    go_to_compute(8'd1);
    for (int j = 0; j <= 6; j++) begin
      chk("re_done", bus.done_o, (j == 3) ? 1 : 0);
      chk("re_busy", bus.busy_o, (j < 3) ? 1 : 0);
      bus.start_i      = (j == 1);
      bus.vec_num_i    = 8'd5;
      bus.sa_en_down_i = (j == 2) ? 5'b10000 : 5'b00000;
      tick();
    end

    // ---- K=0: immediate done, no reads ----
    bus.vec_num_i = 8'd0;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
    chk("k0_done", bus.done_o, 1);
    chk("k0_busy", bus.busy_o, 0);
    chk("k0_wen",  bus.w_rd_en_o, 0);
    chk("k0_aen",  bus.a_rd_en_o, 0);
    tick();
    chk("k0_done_clr", bus.done_o, 0);
    chk("k0_busy2",    bus.busy_o, 0);

    // Abort while idle does nothing.
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("idle_abort_busy", bus.busy_o, 0);
    chk("idle_abort_done", bus.done_o, 0);

    // ---- Reset asserted mid-LOAD ----
    bus.vec_num_i = 8'd3;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
    repeat (3) tick();                        // T+4
    chk("pre_rst_wen", bus.w_rd_en_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_wen",  bus.w_rd_en_o, 0);
    chk("arst_addr", bus.w_rd_addr_o, 0);
    chk("arst_mode", bus.sa_mode_o, 0);
    chk("arst_enup", bus.sa_en_up_o, 0);
    chk("arst_dup",  bus.sa_data_up_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy_o, 0);
    repeat (3) tick();
    chk("post_rst_busy2", bus.busy_o, 0);
    chk("post_rst_wen",   bus.w_rd_en_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
